dff_pipe_set_en: RTL and testbench

DFF_PIPE_SET_EN -- requirements
Module: dff_pipe_set_en

---
 rtl/dff_pipe_set_en.sv | 115 +++++++++++
 tb/tb_dff_pipe_set_en.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_set_en.sv
// Purpose : DEPTH-stage valid/ready register pipeline with bubble collapse, sync flush and
//           data registers preset to SET_VALUE on reset.
// Latency : DEPTH cycles from input transfer to out_valid when empty; 1 transfer/cycle when full.
// Backpr. : out_ready low stalls the out stage; upstream entries still collapse into empty stages.
module dff_pipe_set_en #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    // Per-stage state: valid bit and data register.
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [OCC_W-1:0] r_occ;

    // Per-stage combinational controls.
    logic [DEPTH-1:0] w_rdy;      // stage can take a new entry this cycle
    logic [DEPTH-1:0] w_ld;       // stage loads (data enable)
    logic [DEPTH-1:0] w_drain;    // stage hands its entry onward
    logic [DEPTH-1:0] w_v_nxt;
    logic [WIDTH-1:0] w_nxt_d [DEPTH];
    logic [OCC_W-1:0] w_occ_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Flush blocks acceptance so no entry is taken in the same cycle the pipe is cleared.
    assign in_ready   = w_rdy[0] & ~flush;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_v[DEPTH-1] & out_ready & ~flush;

    assign out_valid  = r_v[DEPTH-1];
    assign out_data   = r_d[DEPTH-1];
    assign occupancy  = r_occ;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // Readiness ripples back from the output: a stage is free if empty or if it is moving on.
        if (g == DEPTH - 1) begin : g_last
            assign w_rdy[g]   = ~r_v[g] | out_ready;
            assign w_drain[g] = r_v[g] & out_ready;
        end else begin : g_mid
            assign w_rdy[g]   = ~r_v[g] | w_rdy[g+1];
            assign w_drain[g] = r_v[g] & w_rdy[g+1];
        end

        // Stage 0 fills from the input port, later stages from their predecessor.
        if (g == 0) begin : g_first
            assign w_ld[g]    = w_in_xfer;
            assign w_nxt_d[g] = in_data;
        end else begin : g_follow
            assign w_ld[g]    = r_v[g-1] & w_rdy[g] & ~flush;
            assign w_nxt_d[g] = r_d[g-1];
        end

        // A refill wins over a drain; flush clears regardless.
        assign w_v_nxt[g] = ~flush & (w_ld[g] | (r_v[g] & ~w_drain[g]));
    end

    // Occupancy tracks transfers rather than re-counting valid bits every cycle.
    always_comb begin
        w_occ_nxt = r_occ;
        if (flush) begin
            w_occ_nxt = '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            w_occ_nxt = r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            w_occ_nxt = r_occ - OCC_W'(1);
        end
    end

    // Valid bits and occupancy: cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            r_v   <= w_v_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    // Data registers: preset on reset, otherwise written only when their stage loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_d[s] <= SET_VALUE;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (w_ld[s]) begin
                    r_d[s] <= w_nxt_d[s];
                end
            end
        end
    end

    // The transfer-based count must always agree with the valid bits and stay within DEPTH.
    a_occ_match: assert property (@(posedge clk) disable iff (rst)
        int'(r_occ) == $countones(r_v));
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        int'(r_occ) <= int'(DEPTH));

endmodule

// File: tb/tb_dff_pipe_set_en.sv
// Bench for dff_pipe_set_en: DEPTH=2 instance against a queue-of-positions reference model,
// plus a DEPTH=1 instance driven with simultaneous push/pop.
// Directed scenarios first, then randomized traffic with occasional flush and one mid-run reset.
module tb_dff_pipe_set_en;

    localparam int D = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    // DEPTH=1 instance
    logic        f1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic [0:0]  occ1;

    dff_pipe_set_en #(.WIDTH(32), .DEPTH(2), .SET_VALUE(32'hFFFF_FFFF)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    dff_pipe_set_en #(.WIDTH(32), .DEPTH(1), .SET_VALUE(32'hFFFF_FFFF)) u_dut1 (
        .clk(clk), .rst(rst), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: in-flight entries oldest first, each with its stage position.
    // Each cycle an entry moves one stage forward unless that would collide with the entry ahead.
    logic [31:0] m_dat[$];
    int          m_pos[$];
    logic [31:0] m_last;     // value sitting in the output stage register

    task automatic model_reset();
        m_dat.delete();
        m_pos.delete();
        m_last = 32'hFFFF_FFFF;
    endtask

    task automatic model_step(input bit iv, input logic [31:0] id, input bit ordy, input bit fl,
                              input bit commit, output bit irdy);
        int          np[$];
        logic [31:0] nd[$];
        int          lim;
        int          p;
        bit          pop;
        logic [31:0] last;
        pop  = !fl && ordy && (m_pos.size() > 0) && (m_pos[0] == D - 1);
        lim  = D;
        last = m_last;
        foreach (m_pos[i]) begin
            if (i == 0 && pop) continue;
            p = m_pos[i] + 1;
            if (p > lim - 1) p = lim - 1;
            if (p == D - 1 && m_pos[i] != D - 1) last = m_dat[i];
            np.push_back(p);
            nd.push_back(m_dat[i]);
            lim = p;
        end
        irdy = !fl && (np.size() == 0 || np[np.size()-1] > 0);
        if (irdy && iv) begin
            np.push_back(0);
            nd.push_back(id);
        end
        if (commit) begin
            if (fl) begin
                m_pos.delete();
                m_dat.delete();
            end else begin
                m_pos  = np;
                m_dat  = nd;
                m_last = last;
            end
        end
    endtask

    // One clock cycle on the DEPTH=2 instance: drive, check combinational view, clock, advance model.
    task automatic cyc(input bit iv, input logic [31:0] id, input bit ordy, input bit fl, input string tag);
        bit irdy;
        bit ovld;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        model_step(iv, id, ordy, fl, 1'b0, irdy);
        ovld = (m_pos.size() > 0) && (m_pos[0] == D - 1);
        chk({tag, ".in_ready"},  64'(in_ready),  64'(irdy));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ovld));
        chk({tag, ".out_data"},  64'(out_data),  64'(m_last));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(m_pos.size()));
        @(posedge clk);
        #1;
        model_step(iv, id, ordy, fl, 1'b1, irdy);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        f1 = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
        model_reset();

        // Reset state, both instances; in_ready follows !flush while in reset.
        #2;
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.out_data",  64'(out_data),  64'(32'hFFFF_FFFF));
        chk("rst.occupancy", 64'(occupancy), 64'(0));
        chk("rst.in_ready",  64'(in_ready),  64'(1));
        flush = 1'b1;
        #1;
        chk("rst.in_ready_flush", 64'(in_ready), 64'(0));
        flush = 1'b0;
        chk("rst1.out_data", 64'(od1), 64'(32'hFFFF_FFFF));
        chk("rst1.occ",      64'(occ1), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // DEPTH=1: push and pop every cycle -> one transfer per cycle, occupancy stays 1.
        iv1 = 1'b1; id1 = 32'h1000; or1 = 1'b1;
        @(negedge clk);
        chk("d1.first.in_ready",  64'(ir1), 64'(1));
        chk("d1.first.out_valid", 64'(ov1), 64'(0));
        @(posedge clk);
        #1;
        for (int k = 1; k <= 16; k++) begin
            id1 = 32'h1000 + 32'(k);
            @(negedge clk);
            chk("d1.tp.in_ready",  64'(ir1),  64'(1));
            chk("d1.tp.out_valid", 64'(ov1),  64'(1));
            chk("d1.tp.out_data",  64'(od1),  64'(32'h1000 + 32'(k - 1)));
            chk("d1.tp.occ",       64'(occ1), 64'(1));
            @(posedge clk);
            #1;
        end
        iv1 = 1'b0;
        @(posedge clk);
        #1;
        chk("d1.drain.out_valid", 64'(ov1),  64'(0));
        chk("d1.drain.occ",       64'(occ1), 64'(0));
        chk("d1.drain.out_data",  64'(od1),  64'(32'h1010));
        or1 = 1'b0;

        // Streaming with out_ready held high.
        for (int k = 1; k <= 4; k++) cyc(1'b1, 32'(k), 1'b1, 1'b0, "stream");
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "stream.tail");

        // Backpressure: five offers, two accepted, then drain in order.
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'h50 + 32'(k), 1'b0, 1'b0, "bp.fill");
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, "bp.drain");

        // Bubble collapse: A, idle, B with the output stalled.
        cyc(1'b1, 32'hA, 1'b0, 1'b0, "bubble.a");
        cyc(1'b0, 32'h0, 1'b0, 1'b0, "bubble.idle");
        cyc(1'b1, 32'hB, 1'b0, 1'b0, "bubble.b");
        cyc(1'b1, 32'hC, 1'b0, 1'b0, "bubble.full");

        // Flush with a full pipe and an offered value.
        cyc(1'b1, 32'hDEAD, 1'b1, 1'b1, "flush");
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "flush.after");
        chk("flush.kept_out_data", 64'(out_data), 64'(32'hA));

        // Fill, then assert reset between edges: outputs must react before the next edge.
        cyc(1'b1, 32'h111, 1'b0, 1'b0, "prerst");
        cyc(1'b1, 32'h222, 1'b0, 1'b0, "prerst");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'(0));
        chk("midrst.out_data",  64'(out_data),  64'(32'hFFFF_FFFF));
        chk("midrst.occupancy", 64'(occupancy), 64'(0));
        chk("midrst.in_ready",  64'(in_ready),  64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 32'h333, 1'b1, 1'b0, "postrst");
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "postrst");
        cyc(1'b0, 32'h0, 1'b1, 1'b0, "postrst");

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                $urandom_range(0, 31) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
